// File: rtl/sr_excitation_driver.sv
// Write-side driver for a bank of external SR cells: derives S/R excitation from live Q feedback.
// Readback check with bounded retries is built only when SR_EXC_VERIFY_EN is defined.
module sr_excitation_driver #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_target,
   input  logic [WIDTH-1:0] i_q_fb,
   output logic [WIDTH-1:0] o_s_out,
   output logic [WIDTH-1:0] o_r_out,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [WIDTH-1:0] o_err_mask
);

   typedef enum logic [1:0] {StIdle, StDrive, StRelease, StCheck} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_s, w_s_d;
   logic [WIDTH-1:0] r_r, w_r_d;
   logic [WIDTH-1:0] r_target, w_target_d;
   logic [3:0]       r_cnt, w_cnt_d;
   logic             r_done, w_done_d;
`ifdef SR_EXC_VERIFY_EN
   logic [2:0]       r_retry, w_retry_d;
   logic             r_err, w_err_d;
   logic [WIDTH-1:0] r_err_mask, w_err_mask_d;
`endif

   always_comb begin
      w_state_d  = r_state;
      w_s_d      = r_s;
      w_r_d      = r_r;
      w_target_d = r_target;
      w_cnt_d    = r_cnt;
      w_done_d   = 1'b0;
`ifdef SR_EXC_VERIFY_EN
      w_retry_d    = r_retry;
      w_err_d      = 1'b0;
      w_err_mask_d = r_err_mask;
`endif
      case (r_state)
         StIdle: begin
            if (i_in_valid) begin
               // S and R are disjoint by construction: S needs t&~q, R needs ~t&q
               w_target_d = i_in_target;
               w_s_d      = i_in_target & ~i_q_fb;
               w_r_d      = ~i_in_target & i_q_fb;
               w_cnt_d    = 4'd0;
               w_state_d  = StDrive;
`ifdef SR_EXC_VERIFY_EN
               w_retry_d    = 3'd0;
               w_err_mask_d = '0;
`endif
            end
         end
         StDrive: begin
            if (r_cnt == 4'(PULSE_CYC - 1)) begin
               w_s_d     = '0;
               w_r_d     = '0;
               w_state_d = StRelease;
            end else begin
               w_cnt_d = r_cnt + 4'd1;
            end
         end
         StRelease: begin
`ifdef SR_EXC_VERIFY_EN
            w_state_d = StCheck;
`else
            w_state_d = StIdle;
            w_done_d  = 1'b1;
`endif
         end
`ifdef SR_EXC_VERIFY_EN
         StCheck: begin
            if (i_q_fb == r_target) begin
               w_state_d    = StIdle;
               w_done_d     = 1'b1;
               w_err_mask_d = '0;
            end else if (r_retry < 3'(MAX_RETRY)) begin
               w_retry_d = r_retry + 3'd1;
               w_s_d     = r_target & ~i_q_fb;
               w_r_d     = ~r_target & i_q_fb;
               w_cnt_d   = 4'd0;
               w_state_d = StDrive;
            end else begin
               w_state_d    = StIdle;
               w_done_d     = 1'b1;
               w_err_d      = 1'b1;
               w_err_mask_d = i_q_fb ^ r_target;
            end
         end
`endif
         default: begin
            w_state_d = StIdle;
            w_s_d     = '0;
            w_r_d     = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_s      <= '0;
         r_r      <= '0;
         r_target <= '0;
         r_cnt    <= 4'd0;
         r_done   <= 1'b0;
`ifdef SR_EXC_VERIFY_EN
         r_retry    <= 3'd0;
         r_err      <= 1'b0;
         r_err_mask <= '0;
`endif
      end else begin
         r_state  <= w_state_d;
         r_s      <= w_s_d;
         r_r      <= w_r_d;
         r_target <= w_target_d;
         r_cnt    <= w_cnt_d;
         r_done   <= w_done_d;
`ifdef SR_EXC_VERIFY_EN
         r_retry    <= w_retry_d;
         r_err      <= w_err_d;
         r_err_mask <= w_err_mask_d;
`endif
      end
   end

   assign o_in_ready = (r_state == StIdle) && !i_rst;
   assign o_busy     = (r_state != StIdle);
   assign o_s_out    = r_s;
   assign o_r_out    = r_r;
   assign o_done     = r_done;
`ifdef SR_EXC_VERIFY_EN
   assign o_err      = r_err;
   assign o_err_mask = r_err_mask;
`else
   assign o_err      = 1'b0;
   assign o_err_mask = '0;

   // Latched target and retry budget only matter to the readback check.
   logic w_unused_cfg;
   assign w_unused_cfg = ^{r_target, 3'(MAX_RETRY)};
`endif

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Directed bench for sr_excitation_driver with a behavioural SR cell bank (stuck/ignore faults).
module tb_sr_excitation_driver;

   localparam int unsigned W  = 4;
   localparam int unsigned P  = 2;
   localparam int unsigned MR = 2;
`ifdef SR_EXC_VERIFY_EN
   localparam int L = P + 2;
`else
   localparam int L = P + 1;
`endif

   logic         clk, rst, in_valid, in_ready, busy, done, err;
   logic [W-1:0] in_target, q_fb, s_out, r_out, err_mask;

   logic [W-1:0] cell_q, ign, prev_s, cell_load_val, ign_init, stuck0;
   logic         cell_load;

   int n_cmp, n_bad;
   int lat;
   logic res_err, busy0;
   logic [W-1:0] res_mask;
   logic [W-1:0] s_tr [16];
   logic [W-1:0] r_tr [16];

   sr_excitation_driver #(.WIDTH(W), .PULSE_CYC(P), .MAX_RETRY(MR)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_target (in_target),
      .i_q_fb      (q_fb),
      .o_s_out     (s_out),
      .o_r_out     (r_out),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err),
      .o_err_mask  (err_mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cell bank: stuck0 bits read back 0; ign bits ignore S/R until their first S pulse ends.
   assign q_fb = cell_q & ~stuck0;
   always @(posedge clk) begin
      if (cell_load) begin
         cell_q <= cell_load_val;
         ign    <= ign_init;
         prev_s <= '0;
      end else begin
         for (int i = 0; i < W; i++) begin
            if (s_out[i] && !ign[i]) cell_q[i] <= 1'b1;
            else if (r_out[i] && !ign[i]) cell_q[i] <= 1'b0;
            if (ign[i] && prev_s[i] && !s_out[i]) ign[i] <= 1'b0;
         end
         prev_s <= s_out;
      end
   end

   always @(negedge clk) begin
      if ((s_out & r_out) != '0)
         $display("FAIL sr_overlap: s_out=%b r_out=%b required s_out&r_out=0", s_out, r_out);
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic load_cells(input logic [W-1:0] val, input logic [W-1:0] ign_m,
                             input logic [W-1:0] stuck_m);
      cell_load_val = val;
      ign_init      = ign_m;
      stuck0        = stuck_m;
      cell_load     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cell_load = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] tgt);
      lat = -1;
      res_err = 1'bx;
      res_mask = 'x;
      for (int i = 0; i < 16; i++) begin
         s_tr[i] = 'x;
         r_tr[i] = 'x;
      end
      in_target = tgt;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      s_tr[0] = s_out;
      r_tr[0] = r_out;
      busy0   = busy;
      for (int n = 1; n < 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n < 16) begin
            s_tr[n] = s_out;
            r_tr[n] = r_out;
         end
         if (done) begin
            lat      = n;
            res_err  = err;
            res_mask = err_mask;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cell_load = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (s_out !== 4'b0000) begin n_bad++; $display("FAIL reset_s got=%b want=0000", s_out); end
      n_cmp++; if (r_out !== 4'b0000) begin n_bad++; $display("FAIL reset_r got=%b want=0000", r_out); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
      n_cmp++; if (err_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_mask got=%b want=0000", err_mask); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst got=%b want=0", in_ready); end
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got=%b want=1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_cells(4'b0110, 4'b0000, 4'b0000);
      send(4'b1010);
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b want=1", busy0); end
      n_cmp++; if (s_tr[0] !== 4'b1000) begin n_bad++; $display("FAIL basic_s0 got=%b want=1000", s_tr[0]); end
      n_cmp++; if (r_tr[0] !== 4'b0100) begin n_bad++; $display("FAIL basic_r0 got=%b want=0100", r_tr[0]); end
      n_cmp++; if (s_tr[1] !== 4'b1000) begin n_bad++; $display("FAIL basic_s1 got=%b want=1000", s_tr[1]); end
      n_cmp++; if (r_tr[1] !== 4'b0100) begin n_bad++; $display("FAIL basic_r1 got=%b want=0100", r_tr[1]); end
      n_cmp++; if ({s_tr[2], r_tr[2]} !== 8'h00) begin n_bad++; $display("FAIL basic_release got=%b/%b want=0000/0000", s_tr[2], r_tr[2]); end
      n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, L); end
      n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b want=0", res_err); end
      n_cmp++; if (q_fb !== 4'b1010) begin n_bad++; $display("FAIL basic_q got=%b want=1010", q_fb); end
   endtask

   task automatic test_noop();
      load_cells(4'b0011, 4'b0000, 4'b0000);
      send(4'b0011);
      n_cmp++; if ({s_tr[0], r_tr[0]} !== 8'h00) begin n_bad++; $display("FAIL noop_sr got=%b/%b want=0000/0000", s_tr[0], r_tr[0]); end
      n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL noop_latency got=%0d want=%0d", lat, L); end
      n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL noop_err got=%b want=0", res_err); end
   endtask

   task automatic test_stuck();
      load_cells(4'b0000, 4'b0000, 4'b0001);
      send(4'b0001);
      n_cmp++; if (s_tr[0] !== 4'b0001) begin n_bad++; $display("FAIL stuck_s0 got=%b want=0001", s_tr[0]); end
      n_cmp++; if (r_tr[0] !== 4'b0000) begin n_bad++; $display("FAIL stuck_r0 got=%b want=0000", r_tr[0]); end
`ifdef SR_EXC_VERIFY_EN
      n_cmp++; if (s_tr[4] !== 4'b0001) begin n_bad++; $display("FAIL stuck_s4 got=%b want=0001", s_tr[4]); end
      n_cmp++; if (s_tr[8] !== 4'b0001) begin n_bad++; $display("FAIL stuck_s8 got=%b want=0001", s_tr[8]); end
      n_cmp++; if (r_tr[8] !== 4'b0000) begin n_bad++; $display("FAIL stuck_r8 got=%b want=0000", r_tr[8]); end
      n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL stuck_latency got=%0d want=12", lat); end
      n_cmp++; if (res_err !== 1'b1) begin n_bad++; $display("FAIL stuck_err got=%b want=1", res_err); end
      n_cmp++; if (res_mask !== 4'b0001) begin n_bad++; $display("FAIL stuck_mask got=%b want=0001", res_mask); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL stuck_err_pulse got=%b want=0", err); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stuck_done_pulse got=%b want=0", done); end
      n_cmp++; if (err_mask !== 4'b0001) begin n_bad++; $display("FAIL stuck_mask_held got=%b want=0001", err_mask); end
`else
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL stuck_latency got=%0d want=3", lat); end
      n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL stuck_err got=%b want=0", res_err); end
      n_cmp++; if (res_mask !== 4'b0000) begin n_bad++; $display("FAIL stuck_mask got=%b want=0000", res_mask); end
`endif
   endtask

   task automatic test_retry();
      load_cells(4'b0000, 4'b0100, 4'b0000);
      send(4'b0100);
      n_cmp++; if (s_tr[0] !== 4'b0100) begin n_bad++; $display("FAIL retry_s0 got=%b want=0100", s_tr[0]); end
      n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL retry_err got=%b want=0", res_err); end
`ifdef SR_EXC_VERIFY_EN
      n_cmp++; if (s_tr[4] !== 4'b0100) begin n_bad++; $display("FAIL retry_s4 got=%b want=0100", s_tr[4]); end
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL retry_latency got=%0d want=8", lat); end
      n_cmp++; if (res_mask !== 4'b0000) begin n_bad++; $display("FAIL retry_mask got=%b want=0000", res_mask); end
      n_cmp++; if (q_fb !== 4'b0100) begin n_bad++; $display("FAIL retry_q got=%b want=0100", q_fb); end
`else
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL retry_latency got=%0d want=3", lat); end
      n_cmp++; if (q_fb !== 4'b0000) begin n_bad++; $display("FAIL retry_q got=%b want=0000", q_fb); end
`endif
   endtask

   task automatic test_rst_mid();
      logic seen_done;
      load_cells(4'b0000, 4'b0000, 4'b0000);
      in_target = 4'b1111;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (s_out !== 4'b1111) begin n_bad++; $display("FAIL rstmid_drive got=%b want=1111", s_out); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({s_out, r_out} !== 8'h00) begin n_bad++; $display("FAIL rstmid_sr got=%b/%b want=0000/0000", s_out, r_out); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b want=0", done); end
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", in_ready); end
      seen_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got=%b want=0", seen_done); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] bs [16];
      logic [W-1:0] br [16];
      logic         bb [16];
      logic         brdy [16];
      int           dk [3];
      int           dones;
      load_cells(4'b0000, 4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) dk[i] = -1;
      dones     = 0;
      in_target = 4'hF;
      in_valid  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k < 16) begin
            bs[k] = s_out; br[k] = r_out; bb[k] = busy; brdy[k] = in_ready;
         end
         if (done) begin
            dk[dones] = k;
            dones++;
            if (dones == 1) in_target = 4'h0;
            else if (dones == 2) in_target = 4'h5;
            else begin
               in_valid = 1'b0;
               break;
            end
         end
         @(posedge clk);
      end
      in_valid = 1'b0;
      n_cmp++; if (dk[0] !== L) begin n_bad++; $display("FAIL b2b_done1 got=%0d want=%0d", dk[0], L); end
      n_cmp++; if (dk[1] !== 2*L+1) begin n_bad++; $display("FAIL b2b_done2 got=%0d want=%0d", dk[1], 2*L+1); end
      n_cmp++; if (dk[2] !== 3*L+2) begin n_bad++; $display("FAIL b2b_done3 got=%0d want=%0d", dk[2], 3*L+2); end
      n_cmp++; if (bs[0] !== 4'hF) begin n_bad++; $display("FAIL b2b_s_first got=%b want=1111", bs[0]); end
      n_cmp++; if (brdy[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_busy got=%b want=0", brdy[1]); end
      n_cmp++; if (brdy[L] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_done got=%b want=1", brdy[L]); end
      n_cmp++; if (bb[L+1] !== 1'b1) begin n_bad++; $display("FAIL b2b_no_gap got=%b want=1", bb[L+1]); end
      n_cmp++; if (br[L+1] !== 4'hF) begin n_bad++; $display("FAIL b2b_r_second got=%b want=1111", br[L+1]); end
      n_cmp++; if (bs[L+1] !== 4'h0) begin n_bad++; $display("FAIL b2b_s_second got=%b want=0000", bs[L+1]); end
      n_cmp++; if (bs[2*L+2] !== 4'h5) begin n_bad++; $display("FAIL b2b_s_third got=%b want=0101", bs[2*L+2]); end
      n_cmp++; if (br[2*L+2] !== 4'h0) begin n_bad++; $display("FAIL b2b_r_third got=%b want=0000", br[2*L+2]); end
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_target     = '0;
      cell_load     = 1'b1;
      cell_load_val = '0;
      ign_init      = '0;
      stuck0        = '0;
      test_reset();
      test_basic();
      test_noop();
      test_stuck();
      test_retry();
      test_rst_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sr_excitation_driver.md
Name: sr_excitation_driver

Overview:
Write-side driver for a bank of WIDTH external SR flip-flops (set/reset storage cells, sync reset, S/R sampled on posedge clk).
- Accepts a target word over a valid/ready handshake.
- Derives per-bit S/R excitation from the flop excitation table against the live Q feedback.
- Pulses S/R, releases them, and verifies readback with bounded retries.
- Guarantees the illegal S=R=1 combination is never driven.

Parameters:
WIDTH, 8, number of SR cells driven (1..32)
PULSE_CYC, 2, cycles S/R held asserted per drive attempt (1..15)
MAX_RETRY, 2, extra drive attempts after first failed check (0..7)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  target word offered
in_ready  output  1  block can accept; equals (state==IDLE) && !rst
in_target  input  WIDTH  desired Q value per cell
q_fb  input  WIDTH  live Q outputs of the SR cells
s_out  output  WIDTH  registered S drive to cells
r_out  output  WIDTH  registered R drive to cells
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = target not reached
err_mask  output  WIDTH  q_fb^target at final check; held until next accept

Behaviour:
- Reset (sync, on an edge with rst=1): state=IDLE, s_out=0, r_out=0, done=0, err=0, err_mask=0, retry count=0, latched target=0.
- Reset mid-operation: abort at that edge, S/R forced to 0, no done pulse.
- States: IDLE, DRIVE, RELEASE, CHECK.
- IDLE:
  - On an edge with in_valid && in_ready (accept edge E0): latch in_target, retry=0, enter DRIVE.
  - On the same edge, load the excitation from q_fb sampled at that edge.
- Excitation per bit i (t = target, q = q_fb):
  - q=0, t=0 -> S=0, R=0.
  - q=0, t=1 -> S=1, R=0.
  - q=1, t=0 -> S=0, R=1.
  - q=1, t=1 -> S=0, R=0.
  - Don't-cares resolve to 0. s_out & r_out == 0 at all times, by construction.
- DRIVE:
  - s_out/r_out are held constant for exactly PULSE_CYC cycles. They are not recomputed, because a held S or R is idempotent.
  - Then enter RELEASE, with s_out=r_out=0 from that edge.
- RELEASE: 1 cycle with S/R=0 for cell settle, then enter CHECK.
- CHECK: sample q_fb and compare to the latched target.
  - Match: next edge -> IDLE, done=1, err=0, err_mask=0.
  - Mismatch and retry<MAX_RETRY: retry++, next edge -> DRIVE, with the excitation reloaded from q_fb at that edge.
  - Mismatch and retry==MAX_RETRY: next edge -> IDLE, done=1, err=1, err_mask=q_fb^target.
- Latency:
  - Success on first try: done high in the cycle starting at edge E0+PULSE_CYC+2.
  - Each retry adds PULSE_CYC+2 cycles.
- done/err are single-cycle pulses. in_ready is high in the same cycle as done, so back-to-back accept is allowed: an accept on the edge ending the done cycle is legal.
- Target already equal to q_fb: DRIVE still runs with all-zero S/R, and timing is unchanged.
- in_target/q_fb changes outside the accept edge and CHECK/DRIVE-load edges are ignored.
- in_valid while busy: not accepted; the source must hold it.

Optional Feature:
Macro SR_EXC_VERIFY_EN.
- Defined: CHECK state, retry counter and err/err_mask behaviour as above.
- Undefined:
  - RELEASE goes directly to IDLE with done=1.
  - Latency is PULSE_CYC+1 cycles from E0.
  - err and err_mask are tied to 0.
  - MAX_RETRY is ignored.

Test Plan:
- WIDTH=4, PULSE_CYC=2, VERIFY on; model SR cells attached. After rst, send target 4'b1010 with cells at 4'b0110 -> s_out=4'b1000, r_out=4'b0100 for 2 cycles, then 0; done 4 cycles after accept; err=0; Q=1010.
- Cell bit0 stuck at 0, target 4'b0001, MAX_RETRY=2 -> 3 drive attempts with s_out=0001, r_out=0000 each; done at 12 cycles after accept; err=1, err_mask=0001.
- Cell flips on 2nd attempt only (bit2 ignores first pulse), target 4'b0100 -> one retry; done at 8 cycles; err=0.
- Assert rst during DRIVE -> next edge s_out=r_out=0, busy=0, no done pulse; in_ready=1 after rst deasserts.
- in_valid held continuously with targets F, 0, 5 -> accepted only in IDLE, back-to-back with no gap after each done. Every cycle s_out & r_out == 0 (assertion).
- VERIFY off, target 4'b1111 from 4'b0000 -> s_out=1111 for 2 cycles; done 3 cycles after accept; err=0 even if a cell is stuck.
